// File: rtl/pwm_timer_mc.sv
// pwm_timer_mc: multi-channel PWM timer. A shared period counter feeds N_CH shadowed duty comparators.
// Build option PWM_CENTER_ALIGN_EN enables up/down (center-aligned) counting selected by CTRL bit2.

module pwm_timer_mc_ch #(
    parameter int CNT_W = 16
) (
    input  logic             iCLK,
    input  logic             iRSTn,
    input  logic             we,
    input  logic [CNT_W-1:0] wdata,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic             inv_run,
    input  logic             inv_idle,
    output logic             pwm
);
    logic [CNT_W-1:0] duty_r, duty_a;

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            duty_r <= '0;
            duty_a <= '0;
            pwm    <= 1'b0;
        end else begin
            if (we)
                duty_r <= wdata;
            // a write landing on the load edge goes straight into the active copy
            if (load)
                duty_a <= we ? wdata : duty_r;
            if (run)
                pwm <= (cnt < duty_a) ^ inv_run;
            else
                pwm <= inv_idle;
        end
    end
endmodule

module pwm_timer_mc #(
    parameter int CNT_W         = 16,
    parameter int N_CH          = 4,
    parameter int ADDR_W        = 4,
    parameter int END_PULSE_LEN = 10
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iWe,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [CNT_W-1:0]  iWdata,
    input  logic              iStart,
    input  logic              iStop,
    output logic [N_CH-1:0]   oPWM,
    output logic              oBusy,
    output logic              oTimer_End
);
`ifdef PWM_CENTER_ALIGN_EN
    localparam int CTRL_W = 3;
`else
    localparam int CTRL_W = 2;
`endif
    localparam int EW = (END_PULSE_LEN > 1) ? $clog2(END_PULSE_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_t;

    state_t            state;
    logic [CNT_W-1:0]  period_r, cycles_r, period_a, cycles_a;
    logic [CTRL_W-1:0] ctrl_r, ctrl_a;
    logic [CNT_W-1:0]  cnt, cyc, cnt_nx;
    logic [EW-1:0]     end_cnt;
    logic              we_per, we_cyc, we_ctl;
    logic [N_CH-1:0]   we_duty;
    logic              start_acc, run, wrap, load, last;

    assign we_per    = iWe && (iAddr == ADDR_W'(0));
    assign we_cyc    = iWe && (iAddr == ADDR_W'(1));
    assign we_ctl    = iWe && (iAddr == ADDR_W'(2));
    assign start_acc = (state == S_IDLE) && iStart && !iStop;
    assign run       = (state == S_RUN) && !iStop;
    assign load      = start_acc || (run && wrap);
    assign last      = wrap && !ctrl_a[0] && (cyc == cycles_a);

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            period_r <= '0;
            cycles_r <= '0;
            ctrl_r   <= '0;
            period_a <= '0;
            cycles_a <= '0;
            ctrl_a   <= '0;
        end else begin
            if (we_per) period_r <= iWdata;
            if (we_cyc) cycles_r <= iWdata;
            if (we_ctl) ctrl_r   <= iWdata[CTRL_W-1:0];
            if (load) begin
                period_a <= we_per ? iWdata : period_r;
                cycles_a <= we_cyc ? iWdata : cycles_r;
                ctrl_a   <= we_ctl ? iWdata[CTRL_W-1:0] : ctrl_r;
            end
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic             dir, dir_nx;
    logic [CNT_W-1:0] pe;

    always_comb begin
        cnt_nx = cnt + 1'b1;
        dir_nx = dir;
        wrap   = (cnt == period_a);
        pe     = (period_a == '0) ? CNT_W'(1) : period_a;
        if (ctrl_a[2]) begin
            wrap = 1'b0;
            if (dir) begin
                if (cnt == CNT_W'(1)) wrap = 1'b1;
                else                  cnt_nx = cnt - 1'b1;
            end else if (cnt == pe) begin
                // a one-count period has no down leg: turn around at the top
                if (pe == CNT_W'(1)) wrap = 1'b1;
                else begin
                    dir_nx = 1'b1;
                    cnt_nx = cnt - 1'b1;
                end
            end
        end
        if (wrap) begin
            cnt_nx = '0;
            dir_nx = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn)   dir <= 1'b0;
        else if (run) dir <= dir_nx;
        else          dir <= 1'b0;
    end
`else
    always_comb begin
        wrap   = (cnt == period_a);
        cnt_nx = wrap ? '0 : cnt + 1'b1;
    end
`endif

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cyc        <= '0;
            end_cnt    <= '0;
            oBusy      <= 1'b0;
            oTimer_End <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_acc) begin
                    state <= S_RUN;
                    cnt   <= '0;
                    cyc   <= '0;
                    oBusy <= 1'b1;
                end
                S_RUN: begin
                    if (iStop) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        cyc   <= '0;
                        oBusy <= 1'b0;
                    end else if (last) begin
                        state      <= S_END;
                        cnt        <= '0;
                        cyc        <= '0;
                        end_cnt    <= '0;
                        oBusy      <= 1'b0;
                        oTimer_End <= 1'b1;
                    end else begin
                        cnt <= cnt_nx;
                        if (wrap) cyc <= cyc + 1'b1;
                    end
                end
                S_END: begin
                    if (end_cnt == EW'(END_PULSE_LEN - 1)) begin
                        state      <= S_IDLE;
                        oTimer_End <= 1'b0;
                    end else begin
                        end_cnt <= end_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign we_duty[k] = iWe && (iAddr == ADDR_W'(3 + k));

        pwm_timer_mc_ch #(.CNT_W(CNT_W)) u_ch (
            .iCLK     (iCLK),
            .iRSTn    (iRSTn),
            .we       (we_duty[k]),
            .wdata    (iWdata),
            .load     (load),
            .run      (run),
            .cnt      (cnt),
            .inv_run  (ctrl_a[1]),
            .inv_idle (ctrl_r[1]),
            .pwm      (oPWM[k])
        );
    end
endmodule

// File: tb/tb_pwm_timer_mc.sv
// Bench for pwm_timer_mc: directed scenarios plus random traffic against a period-list reference model.
module tb_pwm_timer_mc;
    localparam int CNT_W = 16, N_CH = 4, ADDR_W = 4, EPL = 10;

    logic              iCLK = 1'b0, iRSTn = 1'b0, iWe = 1'b0, iStart = 1'b0, iStop = 1'b0;
    logic [ADDR_W-1:0] iAddr = '0;
    logic [CNT_W-1:0]  iWdata = '0;
    logic [N_CH-1:0]   oPWM;
    logic              oBusy, oTimer_End;

    pwm_timer_mc #(.CNT_W(CNT_W), .N_CH(N_CH), .ADDR_W(ADDR_W), .END_PULSE_LEN(EPL)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iWe(iWe), .iAddr(iAddr), .iWdata(iWdata),
        .iStart(iStart), .iStop(iStop), .oPWM(oPWM), .oBusy(oBusy), .oTimer_End(oTimer_End)
    );

    always #5 iCLK = ~iCLK;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: written registers, active copies, and the cnt values left in this period
    int r_per, r_cyc, r_ctl, a_per, a_cyc, a_ctl;
    int r_duty[N_CH], a_duty[N_CH];
    int ms, mcyc, endleft;
    int seq[$];
    logic [N_CH-1:0] e_pwm;
    logic e_busy, e_end;

    task automatic model_reset();
        r_per = 0; r_cyc = 0; r_ctl = 0; a_per = 0; a_cyc = 0; a_ctl = 0;
        foreach (r_duty[k]) begin r_duty[k] = 0; a_duty[k] = 0; end
        ms = 0; mcyc = 0; endleft = 0; seq.delete();
        e_pwm = '0; e_busy = 0; e_end = 0;
    endtask

    task automatic build_seq();
        int pe;
        seq.delete();
`ifdef PWM_CENTER_ALIGN_EN
        if (a_ctl[2]) begin
            pe = (a_per == 0) ? 1 : a_per;
            for (int i = 0; i <= pe; i++) seq.push_back(i);
            for (int i = pe - 1; i >= 1; i--) seq.push_back(i);
            return;
        end
`endif
        for (int i = 0; i <= a_per; i++) seq.push_back(i);
    endtask

    task automatic model_step();
        int n_per, n_cyc, n_ctl, c, a;
        int n_duty[N_CH];
        logic idl;
        n_per = r_per; n_cyc = r_cyc; n_ctl = r_ctl; n_duty = r_duty;
        a = int'(iAddr);
        if (iWe) begin
            if (a == 0) n_per = int'(iWdata);
            else if (a == 1) n_cyc = int'(iWdata);
            else if (a == 2) n_ctl = int'(iWdata) & 7;
            else if (a >= 3 && a < 3 + N_CH) n_duty[a-3] = int'(iWdata);
        end
        idl = r_ctl[1];
        case (ms)
            0: begin
                e_pwm = {N_CH{idl}};
                if (iStart && !iStop) begin
                    a_per = n_per; a_cyc = n_cyc; a_ctl = n_ctl; a_duty = n_duty;
                    ms = 1; mcyc = 0; e_busy = 1; build_seq();
                end
            end
            1: begin
                if (iStop) begin
                    e_pwm = {N_CH{idl}}; ms = 0; e_busy = 0;
                end else begin
                    c = seq.pop_front();
                    for (int k = 0; k < N_CH; k++) e_pwm[k] = (c < a_duty[k]) ^ a_ctl[1];
                    if (seq.size() == 0) begin
                        if (!a_ctl[0] && mcyc == a_cyc) begin
                            ms = 2; e_busy = 0; e_end = 1; endleft = EPL;
                        end else begin
                            mcyc = (mcyc + 1) % 65536;
                            a_per = n_per; a_cyc = n_cyc; a_ctl = n_ctl; a_duty = n_duty;
                            build_seq();
                        end
                    end
                end
            end
            default: begin
                e_pwm = {N_CH{idl}};
                endleft--;
                if (endleft == 0) begin ms = 0; e_end = 0; end
            end
        endcase
        r_per = n_per; r_cyc = n_cyc; r_ctl = n_ctl; r_duty = n_duty;
    endtask

    task automatic cyc_step(input string tag);
        @(posedge iCLK);
        model_step();
        @(negedge iCLK);
        chk({tag, ".pwm"}, 32'(oPWM), 32'(e_pwm));
        chk({tag, ".busy"}, 32'(oBusy), 32'(e_busy));
        chk({tag, ".end"}, 32'(oTimer_End), 32'(e_end));
    endtask

    task automatic wr(input int a, input int d);
        iWe = 1'b1; iAddr = a[ADDR_W-1:0]; iWdata = d[CNT_W-1:0];
        cyc_step("wr");
        iWe = 1'b0;
    endtask

    task automatic run_n(input string tag, input int n);
        repeat (n) cyc_step(tag);
    endtask

    task automatic start(input string tag);
        iStart = 1'b1;
        cyc_step(tag);
        iStart = 1'b0;
    endtask

    int bcnt, ecnt, p0cnt;

    initial begin
        model_reset();
        repeat (2) @(negedge iCLK);
        chk("rst.pwm", 32'(oPWM), 0);
        chk("rst.busy", 32'(oBusy), 0);
        chk("rst.end", 32'(oTimer_End), 0);
        iRSTn = 1'b1;

        // basic one-shot: 30 busy cycles, 10 end cycles, channel 0 high 9 cycles
        wr(0, 9); wr(1, 2); wr(3, 3); wr(4, 0); wr(5, 10); wr(2, 0);
        start("t1");
        bcnt = int'(oBusy); ecnt = 0; p0cnt = 0;
        repeat (45) begin
            cyc_step("t1");
            bcnt += int'(oBusy); ecnt += int'(oTimer_End); p0cnt += int'(oPWM[0]);
        end
        chk("t1.busy_len", bcnt, 30);
        chk("t1.end_len", ecnt, 10);
        chk("t1.pwm0_high", p0cnt, 9);

        // continuous then abort
        wr(2, 1); wr(0, 4); wr(3, 2);
        start("t2"); run_n("t2", 22);
        iStop = 1'b1; cyc_step("t2.stop"); iStop = 1'b0;
        run_n("t2.after", 5);

        // inversion
        wr(2, 2); wr(0, 3); wr(3, 1); wr(1, 1);
        run_n("t3.idle", 2);
        start("t3"); run_n("t3", 25);

        // shadow update mid-period and on the wrap edge
        wr(0, 7); wr(3, 2); wr(2, 1);
        start("t4"); run_n("t4", 2);
        wr(3, 6); run_n("t4", 3);
        wr(3, 1); run_n("t4", 10);
        iStop = 1'b1; cyc_step("t4.stop"); iStop = 1'b0;

        // boundaries: 1-cycle run, start blocked by stop, start ignored in END
        wr(2, 0); wr(0, 0); wr(1, 0); wr(3, 1);
        start("t5"); run_n("t5", 12);
        iStart = 1'b1; iStop = 1'b1; run_n("t5.both", 3); iStop = 1'b0; iStart = 1'b0;
        start("t5b"); run_n("t5b", 2);
        iStart = 1'b1; run_n("t5.in_end", 4); iStart = 1'b0;
        run_n("t5c", 10);

        // asynchronous reset mid-run
        wr(0, 20); wr(3, 15);
        start("t5r"); run_n("t5r", 5);
        iRSTn = 1'b0;
        #1;
        chk("t5r.pwm", 32'(oPWM), 0);
        chk("t5r.busy", 32'(oBusy), 0);
        chk("t5r.end", 32'(oTimer_End), 0);
        model_reset();
        @(negedge iCLK);
        iRSTn = 1'b1;
        run_n("t5r.after", 3);

`ifdef PWM_CENTER_ALIGN_EN
        wr(2, 5); wr(0, 4); wr(3, 2);
        start("t6"); run_n("t6", 24);
        iStop = 1'b1; cyc_step("t6.stop"); iStop = 1'b0;
        wr(2, 4); wr(0, 1); wr(1, 2);
        start("t6b"); run_n("t6b", 20);
`endif

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            iWe    = ($urandom_range(0, 4) == 0);
            iAddr  = ADDR_W'($urandom_range(0, 15));
            iWdata = CNT_W'($urandom_range(0, 12));
            iStart = ($urandom_range(0, 9) == 0);
            iStop  = ($urandom_range(0, 59) == 0);
            cyc_step("rnd");
        end
        iWe = 1'b0; iStart = 1'b0; iStop = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_timer_mc.md
Name: pwm_timer_mc

Overview:
Multi-channel, parametrised PWM timer with a register-write interface. It is the successor to the single-channel 16-bit timer. One shared period counter drives N_CH independent duty comparators. The block supports one-shot (fixed number of periods) and continuous modes, per-run polarity, abort, and a stretched end-of-run pulse. It sits on the peripheral write bus next to other memory-mapped timers and drives motor/LED PWM pins plus an end interrupt.

Parameters:
CNT_W, 16, width of counter, PERIOD, CYCLES and DUTY registers
N_CH, 4, number of PWM output channels (1..8)
ADDR_W, 4, register address width; 2^ADDR_W >= N_CH+3 required
END_PULSE_LEN, 10, oTimer_End high time in iCLK cycles (>=1)

Ports:
iCLK  in  1  clock
iRSTn  in  1  reset, asynchronous, active-low
iWe  in  1  register write strobe
iAddr  in  ADDR_W  register address
iWdata  in  CNT_W  write data
iStart  in  1  start request (level, sampled each edge)
iStop  in  1  abort request (level, sampled each edge)
oPWM  out  N_CH  PWM outputs, registered
oBusy  out  1  high in RUN state
oTimer_End  out  1  end-of-run pulse, END_PULSE_LEN cycles

Behaviour:
- Register map (write-only, all reset to 0):
  - 0 PERIOD.
  - 1 CYCLES.
  - 2 CTRL: bit0 CONT (1 = continuous), bit1 INV (invert outputs), bit2 see Optional Feature, other bits ignored.
  - 3+k DUTY[k] for k = 0..N_CH-1.
  - Writes to unmapped addresses are ignored.
- Shadowing:
  - Active copies of PERIOD, CYCLES, CTRL and DUTY[] load on the cycle of start acceptance and at every period wrap.
  - Writes during RUN therefore take effect from the next period.
  - A write on the same edge as a wrap is included in that load.
- State machine, one-hot or encoded, states IDLE / RUN / END:
  - IDLE -> RUN when iStart=1 and iStop=0. On entry cnt=0, cyc=0.
  - RUN -> IDLE when iStop=1, next edge. Abort: no end pulse, counters cleared.
  - RUN -> END in one-shot mode when cnt==PERIOD and cyc==CYCLES (and iStop=0).
  - END -> IDLE after END_PULSE_LEN cycles.
  - iStart in RUN or END is ignored. iStop in END is ignored.
- Counting (RUN):
  - cnt increments each cycle. When cnt==PERIOD, cnt wraps to 0 and cyc increments (mod 2^CNT_W).
  - Period length is PERIOD+1 cycles. PERIOD=0 gives a 1-cycle period.
  - One-shot run length is (PERIOD+1)*(CYCLES+1) cycles.
  - In continuous mode cyc still counts but never ends the run.
- PWM outputs:
  - Raw compare for channel k: raw[k] = (cnt < DUTY[k]), evaluated in RUN only.
  - DUTY=0 gives always low. DUTY > PERIOD gives always high.
  - oPWM[k] is registered as raw[k] XOR INV, with 1 cycle latency from cnt.
  - In IDLE/END, oPWM[k] = INV (idle level). After reset INV=0, so oPWM=0.
- Outputs:
  - oBusy is high from the edge after start acceptance until the edge after the RUN exit.
  - oTimer_End is high throughout END only: exactly END_PULSE_LEN cycles, starting the cycle after the final cnt==PERIOD.
- Reset: asynchronous at any time. State=IDLE, all registers and counters 0, oPWM=0, oBusy=0, oTimer_End=0.

Optional Feature:
- Macro PWM_CENTER_ALIGN_EN.
- Defined: CTRL bit2 (CA)=1 selects center-aligned counting.
  - cnt counts up 0..PERIOD, then down PERIOD-1..1, then repeats.
  - The period is 2*PERIOD cycles (PERIOD=0 is treated as 1).
  - The wrap (cyc increment and shadow load) occurs at the cnt=1 to 0 turnaround.
  - The one-shot end is checked at that turnaround. The compare rule is unchanged, giving symmetric pulses.
- Undefined: CTRL bit2 is ignored and the block is edge-aligned only. No up/down logic is synthesised.

Test Plan:
1. Basic one-shot. Write PERIOD=9, CYCLES=2, DUTY0=3, DUTY1=0, DUTY2=10, CTRL=0, then pulse iStart.
   - oBusy high 30 cycles.
   - oPWM[0] high 3 of every 10 cycles (3 periods). oPWM[1] stays 0. oPWM[2] stays 1 during RUN.
   - Then oTimer_End high exactly 10 cycles, then IDLE.
2. Continuous and abort. CTRL=1, PERIOD=4, DUTY0=2, start.
   - After 23 cycles assert iStop: oBusy falls next edge, oPWM=0, oTimer_End never asserts.
3. Inversion. CTRL=2, PERIOD=3, DUTY0=1.
   - oPWM[0]=1 in IDLE.
   - During RUN: low 1 cycle, high 3 cycles per period.
   - Returns to 1 after the run.
4. Shadow update. Run PERIOD=7, DUTY0=2, continuous. Mid-period write DUTY0=6.
   - Current period keeps 2 high cycles; the next period has 6.
   - Writing during the wrap cycle takes effect in the new period.
5. Boundaries and simultaneous events.
   - PERIOD=0, CYCLES=0, DUTY0=1 gives a 1-cycle run with oPWM[0] high 1 cycle.
   - iStart with iStop held in IDLE keeps IDLE.
   - iStart during END is ignored.
   - iRSTn low mid-RUN clears all outputs immediately.
6. (PWM_CENTER_ALIGN_EN) CTRL=4|1, PERIOD=4, DUTY0=2.
   - cnt sequence 0,1,2,3,4,3,2,1 repeats.
   - oPWM[0] pattern per period 1,1,0,0,0,0,0,1 (delayed 1 cycle).
